// File: rtl/neuron_acc.sv
`default_nettype none
// ============================================================================
// Module   : neuron_acc
// Purpose  : Sequences N_IN multiply terms through the mulfp start/ack/done
//            handshake, accumulates them onto a bias, then rescales,
//            saturates and optionally rectifies the sum to the output format.
// Options  : NEURON_ACC_RELU_EN -- when defined, negative results become 0.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_acc #(
  parameter int N_IN   = 16,
  parameter int PWIDTH = 16,
  parameter int PFR    = 5,
  parameter int ACCW   = 24,
  parameter int OWIDTH = 8,
  parameter int OFR    = 4,
  parameter int IDXW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PWIDTH-1:0] bias,
  output logic [IDXW-1:0]   idx,
  output logic              mul_start,
  input  logic              mul_ack,
  input  logic              mul_done,
  input  logic [PWIDTH-1:0] mul_p,
  output logic [OWIDTH-1:0] y,
  output logic              y_valid,
  input  logic              y_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  // Rescale from Q(PFR) to Q(OFR) is a plain arithmetic right shift (floor).
  localparam int unsigned SH = PFR - OFR;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (OWIDTH - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [IDXW-1:0]        IDX_LAST = IDXW'(N_IN - 1);

  logic [2:0]               state_q, state_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [OWIDTH-1:0]        y_q, y_d;
  logic                     in_ready_q;
  logic                     mul_start_q;
  logic                     y_valid_q;

  logic signed [ACCW-1:0]   w_bias_ext;
  logic signed [ACCW-1:0]   w_p_ext;
  logic signed [ACCW-1:0]   w_acc_sum;
  logic signed [ACCW-1:0]   w_t;
  logic [OWIDTH-1:0]        w_sat;
  logic [OWIDTH-1:0]        w_act;

  assign w_bias_ext = {{(ACCW-PWIDTH){bias[PWIDTH-1]}}, bias};
  assign w_p_ext    = {{(ACCW-PWIDTH){mul_p[PWIDTH-1]}}, mul_p};
  assign w_acc_sum  = acc_q + w_p_ext;
  assign w_t        = acc_q >>> SH;

  // Saturate the rescaled sum, then apply the optional rectifier.
  always_comb begin
    if (w_t > SAT_MAX) begin
      w_sat = {1'b0, {(OWIDTH-1){1'b1}}};
    end else if (w_t < SAT_MIN) begin
      w_sat = {1'b1, {(OWIDTH-1){1'b0}}};
    end else begin
      w_sat = w_t[OWIDTH-1:0];
    end
`ifdef NEURON_ACC_RELU_EN
    w_act = w_sat[OWIDTH-1] ? '0 : w_sat;
`else
    w_act = w_sat;
`endif
  end

  // Next-state logic: handshake sequencing and accumulation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = w_bias_ext;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mul_ack) begin
          // A done coinciding with ack completes the term without visiting WAIT.
          if (mul_done) begin
            acc_d = w_acc_sum;
            if (idx_q == IDX_LAST) begin
              state_d = S_SCALE;
            end else begin
              idx_d   = idx_q + IDXW'(1);
              state_d = S_ISSUE;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mul_done) begin
          acc_d = w_acc_sum;
          if (idx_q == IDX_LAST) begin
            state_d = S_SCALE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_SCALE: begin
        y_d     = w_act;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (y_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // every output is a flop with no input-to-output combinational path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      mul_start_q <= 1'b0;
      y_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      y_q         <= y_d;
      in_ready_q  <= (state_d == S_IDLE);
      mul_start_q <= (state_d == S_ISSUE);
      y_valid_q   <= (state_d == S_OUT);
    end
  end

  assign in_ready  = in_ready_q;
  assign idx       = idx_q;
  assign mul_start = mul_start_q;
  assign y         = y_q;
  assign y_valid   = y_valid_q;

endmodule
`default_nettype wire

// File: doc/neuron_acc.md
# neuron_acc

Sequencer and accumulator for one neuron of the inference engine. It drives the fixed-point multiplier's start/ack/done handshake for `N_IN` successive input·weight terms and accumulates each product onto a bias. It then rescales, saturates and optionally rectifies the sum to the activation format. It sits directly downstream of the `mulfp` stage and feeds the next layer's input buffer.

## Interface
Parameters:
- `N_IN`, 16: number of product terms per neuron (≥1).
- `PWIDTH`, 16: product (`mulfp` output) width, signed.
- `PFR`, 5: fractional bits of products and bias.
- `ACCW`, 24: accumulator width, signed. Must be ≥ `PWIDTH` + clog2(`N_IN`+1).
- `OWIDTH`, 8: activation output width, signed.
- `OFR`, 4: fractional bits of output. Must be ≤ `PFR`.
- `IDXW`, clog2(`N_IN`) (min 1): term index width.

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `rst`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: request to compute one neuron.
- `in_ready`, out, 1: high only in IDLE.
- `bias`, in, `PWIDTH`: bias in Q(`PFR`). Sampled on accept.
- `idx`, out, `IDXW`: current term index, used to address the input/weight memories.
- `mul_start`, out, 1: start to multiplier.
- `mul_ack`, in, 1: multiplier accepted start.
- `mul_done`, in, 1: product valid on `mul_p`.
- `mul_p`, in, `PWIDTH`: signed product in Q(`PFR`).
- `y`, out, `OWIDTH`: activation in Q(`OFR`).
- `y_valid`, out, 1: `y` valid.
- `y_ready`, in, 1: consumer accepts `y`.

## Operation
States are IDLE, ISSUE, WAIT, SCALE and OUT.

- **IDLE**
  - `in_ready`=1.
  - When `in_valid`: set acc ← sign-extended `bias`, set `idx` ← 0, go to ISSUE.
- **ISSUE**
  - `mul_start`=1, held until `mul_ack` is sampled high.
  - On `mul_ack`, go to WAIT.
  - If `mul_done` is also high in that cycle, perform the WAIT completion action immediately instead.
- **WAIT**
  - `mul_start`=0.
  - On `mul_done`: acc ← acc + sign-extended `mul_p`, with two's-complement wrap at `ACCW`.
  - If `idx`==`N_IN`-1, go to SCALE.
  - Otherwise increment `idx` and go to ISSUE.
- **SCALE**
  - Shift: t = acc >>> (`PFR`−`OFR`), arithmetic shift, i.e. floor.
  - Saturate t to [−2^(`OWIDTH`−1), 2^(`OWIDTH`−1)−1].
  - Apply optional ReLU (see Configuration).
  - Register the result into `y`, then go to OUT.
- **OUT**
  - `y_valid`=1, with `y` stable.
  - On `y_ready`, go to IDLE.

General rules:
- `mul_done` is ignored in IDLE, SCALE and OUT.
- `mul_ack` is ignored outside ISSUE.
- `idx` holds its value outside ISSUE/WAIT.
- `in_valid` is ignored unless in IDLE.

## Timing
- All outputs and registers are reset when `rst`=0 at a clock edge:
  - state=IDLE; acc=0, `idx`=0, `y`=0.
  - `y_valid`=0, `mul_start`=0.
  - `in_ready`=1 in the first cycle after reset release.
- Reset mid-operation (any state) aborts the neuron. No partial `y` is ever presented.
- Accept-to-first-`mul_start`: 1 cycle.
- Per term: 1 ISSUE cycle minimum, plus multiplier latency, plus 0 cycles if ack and done coincide.
- Best case (ack immediate, done 1 cycle after ack): 2 cycles/term.
  - Total from accept to `y_valid` = 1 + 2·`N_IN` + 1 cycles (SCALE).
- `in_ready` rises the cycle after `y_valid`&&`y_ready`. There is no back-to-back overlap.
- Backpressure: `y_valid` and `y` stay constant while `y_ready`=0, with no timeout.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `NEURON_ACC_RELU_EN`:
  - Defined: after saturation, any negative value is forced to 0, so `y` ∈ [0, 2^(`OWIDTH`−1)−1].
  - Undefined: the saturated signed value passes unchanged.
- Saturation is always present.

## Test plan
All scenarios use `N_IN`=4, `PFR`=5, `OFR`=4, `OWIDTH`=8, and a multiplier model with ack on the start cycle and done 1 cycle later unless stated otherwise.

- Basic sum: bias=0, products 32,32,32,32 → acc=128 → `y`=64, `idx` sequence 0,1,2,3, `y_valid` at cycle 10 after accept.
- Positive saturation: bias=100, products 2000 each → acc=8100 → t=4050 → `y`=127.
- Negative value and floor: bias=−1, products −64 each → acc=−257 → t=−129 → `y`=−128 without the macro, 0 with `NEURON_ACC_RELU_EN`. Also check bias=−1 with zero products → `y`=−1 (or 0 with ReLU).
- Slow multiplier: `mul_ack` delayed 3 cycles and `mul_done` 4 cycles after ack → `mul_start` held until ack, same `y`, no duplicate accumulation. Also check ack and done in the same cycle → term counted exactly once.
- Backpressure: `y_ready`=0 for 5 cycles → `y`/`y_valid` stable, `in_ready`=0, `in_valid` pulses ignored.
- Reset mid-operation: `rst`=0 during WAIT of term 2 → next cycle state IDLE, all outputs at reset values. A following neuron gives the correct result with no carry-over.
